fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the request-FSM state encoding, the fetched-word field positions
// and the fetch PC increment.
package fetch_pkg;

  // Request FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DROP = 2'b10
  } state_t;

  // Fetched word layout: [31:16] opcode, [15:0] 16-bit constant
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 16;
  localparam int unsigned K16_MSB = 15;
  localparam int unsigned K16_LSB = 0;

  // Byte distance between consecutive fetch addresses
  localparam int unsigned PC_INC  = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {address, word} entries.
// Ports:
//   clk, a_rst        clock, asynchronous active-low reset
//   flush             empties the queue (wins over push and pop)
//   push, wr_data     write one entry; ignored when full without a pop
//   pop               consume the head entry; ignored when empty
//   rd_data           registered head entry; holds its last value when empty
//   count             occupied entries
module fetch_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   a_rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    next_rptr;
  logic [CW-1:0]    remain;
  logic             do_pop;
  logic             do_push;

  // Effective handshakes after empty/full/flush qualification
  always_comb begin
    do_pop    = pop && (count != '0) && !flush;
    remain    = count - CW'(do_pop);
    do_push   = push && !flush && (remain < CW'(DEPTH));
    next_rptr = rptr + PW'(do_pop);
  end

  // Storage, pointers, occupancy and the registered head
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + PW'(1);
      end
      rptr  <= next_rptr;
      count <= count + CW'(do_push) - CW'(do_pop);
      // A push into an otherwise empty queue bypasses storage so the entry
      // is at the head right after the edge that accepted it.
      if (do_push && (remain == '0)) begin
        rd_data <= wr_data;
      end else if (do_pop && (remain != '0)) begin
        rd_data <= mem[next_rptr];
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to memory and
// buffers the returned {address, opcode, constant} entries for the decoder.
// Ports:
//   clk, a_rst              clock, asynchronous active-low reset
//   mem_req, mem_addr       fetch request and its registered byte address
//   mem_ack, mem_data       response strobe and fetched word (same cycle)
//   redirect, redirect_pc   PC write from the ALU; flushes and restarts fetch
//   pop                     decoder consumes the head entry
//   ir_valid                head entry valid
//   ir_out, k16_out, pc_out head opcode, constant and address
//   count_out               occupied entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   a_rst,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   pop,
  output logic                   ir_valid,
  output logic [15:0]            ir_out,
  output logic [15:0]            k16_out,
  output logic [ADDR_W-1:0]      pc_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned FW = ADDR_W + DATA_W;

  state_t            state;
  logic [ADDR_W-1:0] fpc;
  logic [CW-1:0]     count;
  logic [FW-1:0]     head;
  logic [CW-1:0]     avail;
  logic              pop_eff;
  logic              slot_free;
  logic              room_after;
  logic              push;

  // Occupancy seen by the issue decision, with this cycle's pop applied
  always_comb begin
    pop_eff    = pop && (count != '0) && !redirect;
    avail      = count - CW'(pop_eff);
    slot_free  = avail < CW'(DEPTH);
    room_after = (avail + CW'(1)) < CW'(DEPTH);
    push       = (state == WAIT) && mem_ack && !redirect;
  end

  // Request FSM and fetch PC
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      fpc      <= ADDR_W'(RESET_PC);
    end else begin
      if (redirect) fpc <= redirect_pc & ~ADDR_W'(3);
      case (state)
        IDLE: begin
          if (!redirect && slot_free) begin
            mem_addr <= fpc;
            fpc      <= fpc + ADDR_W'(PC_INC);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            // Response still in flight must be swallowed before refetching
            state <= mem_ack ? IDLE : DROP;
          end else if (mem_ack) begin
            if (room_after) begin
              mem_addr <= fpc;
              fpc      <= fpc + ADDR_W'(PC_INC);
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .a_rst   (a_rst),
    .flush   (redirect),
    .push    (push),
    .wr_data ({mem_addr, mem_data}),
    .pop     (pop_eff),
    .rd_data (head),
    .count   (count)
  );

  assign mem_req   = (state == WAIT) || (state == DROP);
  assign ir_valid  = (count != '0);
  assign count_out = count;
  assign pc_out    = head[FW-1:DATA_W];
  assign ir_out    = head[OPC_MSB:OPC_LSB];
  assign k16_out   = head[K16_MSB:K16_LSB];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected request
// addresses and expected head entries; a monitor compares them against
// memory handshakes and decoder pops.
module tb_fetch_queue;

  logic        clk;
  logic        a_rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        pop;
  logic        ir_valid;
  logic [15:0] ir_out;
  logic [15:0] k16_out;
  logic [15:0] pc_out;
  logic [2:0]  count_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_req[$];
  logic [15:0] exp_head[$];

  logic man_mode = 1'b0;
  logic man_ack  = 1'b0;
  logic use_bad  = 1'b0;
  logic bad_seen = 1'b0;

  fetch_queue #(
    .ADDR_W   (16),
    .DEPTH    (4),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .a_rst       (a_rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pop         (pop),
    .ir_valid    (ir_valid),
    .ir_out      (ir_out),
    .k16_out     (k16_out),
    .pc_out      (pc_out),
    .count_out   (count_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] data_of(input logic [15:0] a);
    return {a ^ 16'hA5C3, a + 16'h0101};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [2:0] target, input int budget);
    int n = 0;
    while (count_out !== target && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_count", 32'(count_out), 32'(target));
  endtask

  // Memory model: acknowledges during the cycle after each request edge
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      mem_ack  = mem_req && a_rst && (man_mode ? man_ack : 1'b1);
      mem_data = use_bad ? 32'hDEADBEEF : data_of(mem_addr);
    end
  end

  // Monitor: checks request addresses and consumed head entries
  initial begin
    logic [15:0] pc_e;
    forever begin
      @(negedge clk);
      #1;
      if (a_rst) begin
        if (mem_req && mem_ack) begin
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr 0x%0h, expected no request", mem_addr);
          end else begin
            chk("req_addr", 32'(mem_addr), 32'(exp_req.pop_front()));
          end
        end
        if (ir_valid && pop) begin
          if (exp_head.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got head pc 0x%0h, expected no entry", pc_out);
          end else begin
            pc_e = exp_head.pop_front();
            chk("head_pc", 32'(pc_out), 32'(pc_e));
            chk("head_word", {ir_out, k16_out}, data_of(pc_e));
          end
        end
        if (ir_valid && ({ir_out, k16_out} == 32'hDEADBEEF)) bad_seen = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    pop         = 1'b0;
    #1 a_rst = 1'b0;
    #1;
    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_head", {ir_out, k16_out}, 32'd0);
    cyc();
    cyc();
    a_rst = 1'b1;
    chk("no_req_before_edge", 32'(mem_req), 32'd0);

    // Fill from RESET_PC with single-cycle acks
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0004);
    exp_req.push_back(16'h0008);
    exp_req.push_back(16'h000C);
    wait_count(3'd4, 20);
    cyc();
    cyc();
    chk("full_req_low", 32'(mem_req), 32'd0);
    chk("full_count", 32'(count_out), 32'd4);
    chk("full_head_pc", 32'(pc_out), 32'h0000);

    // One pop on a full queue refills exactly one slot
    exp_head.push_back(16'h0000);
    exp_req.push_back(16'h0010);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("refill_count", 32'(count_out), 32'd4);
    chk("refill_req_low", 32'(mem_req), 32'd0);
    chk("refill_head_pc", 32'(pc_out), 32'h0004);

    // Redirect from a full idle queue, then redirect while a request waits
    man_mode    = 1'b1;
    man_ack     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h2000;
    cyc();
    redirect = 1'b0;
    chk("flush_count", 32'(count_out), 32'd0);
    chk("flush_valid", 32'(ir_valid), 32'd0);
    cyc();
    chk("issue_after_redirect", 32'(mem_addr), 32'h2000);
    exp_req.push_back(16'h2000);
    redirect    = 1'b1;
    redirect_pc = 16'h1236;
    cyc();
    redirect = 1'b0;
    chk("drop_count", 32'(count_out), 32'd0);
    chk("drop_req_held", 32'(mem_req), 32'd1);
    chk("drop_addr_held", 32'(mem_addr), 32'h2000);
    use_bad = 1'b1;
    cyc();
    man_ack = 1'b1;
    cyc();
    man_ack  = 1'b0;
    use_bad  = 1'b0;
    man_mode = 1'b0;
    chk("drop_done_idle", 32'(mem_req), 32'd0);
    chk("drop_nothing_pushed", 32'(count_out), 32'd0);
    exp_req.push_back(16'h1234);
    exp_req.push_back(16'h1238);
    exp_req.push_back(16'h123C);
    exp_req.push_back(16'h1240);
    cyc();
    chk("aligned_redirect_addr", 32'(mem_addr), 32'h1234);
    wait_count(3'd4, 20);

    // Drain with memory stalled, plus one pop on an empty queue
    man_mode = 1'b1;
    exp_head.push_back(16'h1234);
    exp_head.push_back(16'h1238);
    exp_head.push_back(16'h123C);
    exp_head.push_back(16'h1240);
    pop = 1'b1;
    repeat (5) cyc();
    pop = 1'b0;
    chk("empty_pop_count", 32'(count_out), 32'd0);
    chk("empty_valid", 32'(ir_valid), 32'd0);
    chk("empty_head_hold", 32'(pc_out), 32'h1240);
    chk("stalled_req_addr", 32'(mem_addr), 32'h1244);

    // Redirect and ack in the same cycle, then wrap past 0xFFFC
    exp_req.push_back(16'h1244);
    redirect    = 1'b1;
    redirect_pc = 16'hFFF8;
    man_ack     = 1'b1;
    cyc();
    redirect = 1'b0;
    man_ack  = 1'b0;
    man_mode = 1'b0;
    chk("same_cycle_idle", 32'(mem_req), 32'd0);
    chk("same_cycle_count", 32'(count_out), 32'd0);
    exp_req.push_back(16'hFFF8);
    exp_req.push_back(16'hFFFC);
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0004);
    cyc();
    chk("wrap_first_addr", 32'(mem_addr), 32'hFFF8);
    wait_count(3'd4, 20);

    man_mode = 1'b1;
    exp_head.push_back(16'hFFF8);
    exp_head.push_back(16'hFFFC);
    exp_head.push_back(16'h0000);
    pop = 1'b1;
    repeat (3) cyc();
    pop = 1'b0;
    exp_req.push_back(16'h0008);
    exp_req.push_back(16'h000C);
    man_ack = 1'b1;
    cyc();
    cyc();
    man_ack = 1'b0;
    chk("midwait_count", 32'(count_out), 32'd3);
    chk("midwait_req", 32'(mem_req), 32'd1);

    // Asynchronous reset mid-WAIT
    #2 a_rst = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_count", 32'(count_out), 32'd0);
    chk("arst_valid", 32'(ir_valid), 32'd0);
    chk("arst_pc", 32'(pc_out), 32'd0);
    chk("arst_word", {ir_out, k16_out}, 32'd0);
    man_mode = 1'b0;
    cyc();
    cyc();
    a_rst = 1'b1;
    chk("rel_no_req", 32'(mem_req), 32'd0);
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0004);
    exp_req.push_back(16'h0008);
    exp_req.push_back(16'h000C);
    cyc();
    chk("rel_first_req", 32'(mem_req), 32'd1);
    chk("rel_first_addr", 32'(mem_addr), 32'h0000);
    wait_count(3'd4, 20);
    cyc();
    cyc();
    chk("rel_full_req_low", 32'(mem_req), 32'd0);

    chk("no_deadbeef_at_head", 32'(bad_seen), 32'd0);
    chk("exp_req_left", 32'(exp_req.size()), 32'd0);
    chk("exp_head_left", 32'(exp_head.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
